// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: drains a one-cycle-latency synchronous FIFO and sends each word as 8N1 (8E1 with UART_TX_PARITY_EN).
// Ports: clk, srst (sync active-high reset), fifo_empty, fifo_dout[DATA_WD] in;
//        fifo_rd_en (one-cycle read strobe), uart_tx (registered line, idle high),
//        tx_busy (strobe cycle through last stop cycle), tx_done (last stop cycle) out.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_fifo_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int DATA_WD = 8
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               fifo_empty,
  input  logic [DATA_WD-1:0] fifo_dout,
  output logic               fifo_rd_en,
  output logic               uart_tx,
  output logic               tx_busy,
  output logic               tx_done
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
  localparam int BW = DATA_WD > 1 ? $clog2(DATA_WD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_WD - 1);
  if (BAUD_DIV < 2) begin : g_baud_chk
    $error("uart_fifo_tx: BAUD_DIV must be at least 2");
  end
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WD-1:0] sh;
  logic tx_n;
  logic wrap;
  assign wrap = cnt == CNT_MAX;
  // Reset has priority over a pending read so no word is popped while it is asserted.
  assign fifo_rd_en = state == IDLE && !fifo_empty && !srst;
  assign tx_busy = fifo_rd_en || state != IDLE;
  assign tx_done = state == STOP && wrap && !srst;
`ifdef UART_TX_PARITY_EN
  logic par;
  always_ff @(posedge clk) begin
    if (srst) par <= 1'b0;
    else if (state == LOAD) par <= ^fifo_dout;
  end
`endif
  // tx_n is the line level for the next cycle, so the registered line lines up with the state.
  always_comb begin
    state_n = state;
    tx_n = uart_tx;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        state_n = fifo_rd_en ? LOAD : IDLE;
      end
      LOAD: begin
        tx_n = 1'b0;
        state_n = START;
      end
      START: if (wrap) begin
        tx_n = sh[0];
        state_n = DATA;
      end
      DATA: if (wrap) begin
        if (bit_cnt == BIT_MAX) begin
`ifdef UART_TX_PARITY_EN
          tx_n = par;
          state_n = PARITY;
`else
          tx_n = 1'b1;
          state_n = STOP;
`endif
        end else begin
          tx_n = sh[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (wrap) begin
        tx_n = 1'b1;
        state_n = STOP;
      end
`endif
      STOP: if (wrap) begin
        tx_n = 1'b1;
        state_n = IDLE;
      end
      default: begin
        tx_n = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state <= IDLE;
      uart_tx <= 1'b1;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      uart_tx <= tx_n;
      cnt <= (state == IDLE || state == LOAD || wrap) ? '0 : cnt + 1'b1;
      bit_cnt <= state == LOAD ? '0 : (state == DATA && wrap) ? bit_cnt + 1'b1 : bit_cnt;
      sh <= state == LOAD ? fifo_dout : (state == DATA && wrap) ? sh >> 1 : sh;
    end
  end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: self-checking bench for uart_fifo_tx against a frame-level reference model.
module tb_uart_fifo_tx;
  localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = BD * (10 + P);
  localparam int PER = FL + 2;
  logic clk = 1'b0;
  logic srst = 1'b1;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic fifo_rd_en, uart_tx, tx_busy, tx_done;
  logic hide = 1'b0;
  logic [7:0] q[$];
  logic [7:0] byte_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;

  uart_fifo_tx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_WD(8)) dut (
    .clk(clk), .srst(srst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .uart_tx(uart_tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle read latency, empty flag refreshed away from the active edge.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      strobes++;
      if (q.size() > 0) fifo_dout <= q.pop_front();
    end
  end
  always @(negedge clk) fifo_empty = hide || q.size() == 0;

  // Expected line level k cycles after the strobe of a frame carrying b.
  function automatic logic exp_line(input logic [7:0] b, input int k);
    int s;
    if (k < 2) return 1'b1;
    s = (k - 2) / BD;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (P == 1 && s == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic test_reset();
    int t;
    srst = 1'b1;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({uart_tx, fifo_rd_en, tx_busy, tx_done} !== 4'b1000) begin
        n_bad++;
        $display("FAIL reset_idle c=%0d tx/rd/busy/done got %b want 1000", c, {uart_tx, fifo_rd_en, tx_busy, tx_done});
      end
    end
    @(posedge clk); #1 srst = 1'b1;
    q.push_back(8'($urandom));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (fifo_rd_en !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_dominates c=%0d rd_en got %b want 0", c, fifo_rd_en);
      end
    end
    @(posedge clk); #1 srst = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (fifo_rd_en !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_strobe rd_en got %b want 1", fifo_rd_en);
    end
    t = 0;
    while (tx_busy && t < PER + 10) begin @(negedge clk); #1; t++; end
  endtask

  task automatic test_stream(input string name);
    int n, t, i, k;
    logic exp_tx;
    logic [2:0] exp_ctl;
    n = byte_q.size();
    @(posedge clk); #1;
    foreach (byte_q[j]) q.push_back(byte_q[j]);
    t = 0;
    do begin @(negedge clk); #1; t++; end while (!fifo_rd_en && t < 20);
    n_cmp++;
    if (fifo_rd_en !== 1'b1) begin
      n_bad++;
      $display("FAIL %s strobe_timeout rd_en got %b want 1", name, fifo_rd_en);
    end
    for (int g = 0; g < n * PER + 3; g++) begin
      if (g > 0) begin @(negedge clk); #1; end
      i = g / PER;
      k = g % PER;
      if (i < n) begin
        exp_tx = exp_line(byte_q[i], k);
        exp_ctl = {k == 0, k == FL + 1, k <= FL + 1};
      end else begin
        exp_tx = 1'b1;
        exp_ctl = 3'b000;
      end
      n_cmp++;
      if (uart_tx !== exp_tx) begin
        n_bad++;
        $display("FAIL %s line g=%0d uart_tx got %b want %b", name, g, uart_tx, exp_tx);
      end
      n_cmp++;
      if ({fifo_rd_en, tx_done, tx_busy} !== exp_ctl) begin
        n_bad++;
        $display("FAIL %s ctl g=%0d rd/done/busy got %b want %b", name, g, {fifo_rd_en, tx_done, tx_busy}, exp_ctl);
      end
    end
  endtask

  task automatic test_reset_mid_frame(input logic [7:0] b0);
    int t;
    logic [7:0] b1;
    b1 = 8'($urandom);
    @(posedge clk); #1;
    q.push_back(b0);
    q.push_back(b1);
    t = 0;
    do begin @(negedge clk); #1; t++; end while (!fifo_rd_en && t < 20);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({uart_tx, tx_done} !== {exp_line(b0, k), 1'b0}) begin
        n_bad++;
        $display("FAIL midrst_pre k=%0d tx/done got %b want %b", k, {uart_tx, tx_done}, {exp_line(b0, k), 1'b0});
      end
    end
    @(posedge clk); #1 srst = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({fifo_rd_en, tx_done} !== 2'b00) begin
      n_bad++;
      $display("FAIL midrst_during rd/done got %b want 00", {fifo_rd_en, tx_done});
    end
    @(posedge clk); #1 srst = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({uart_tx, tx_done, fifo_rd_en, tx_busy} !== 4'b1011) begin
      n_bad++;
      $display("FAIL midrst_after tx/done/rd/busy got %b want 1011", {uart_tx, tx_done, fifo_rd_en, tx_busy});
    end
    for (int k = 1; k < PER; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({uart_tx, tx_done} !== {exp_line(b1, k), k == FL + 1}) begin
        n_bad++;
        $display("FAIL midrst_next k=%0d tx/done got %b want %b", k, {uart_tx, tx_done}, {exp_line(b1, k), k == FL + 1});
      end
    end
  endtask

  task automatic test_empty_toggle();
    int t, s0;
    logic [7:0] b[2];
    logic exp_tx;
    b[0] = 8'($urandom);
    b[1] = 8'($urandom);
    @(posedge clk); #1;
    q.push_back(b[0]);
    q.push_back(b[1]);
    t = 0;
    do begin @(negedge clk); #1; t++; end while (!fifo_rd_en && t < 20);
    s0 = strobes;
    for (int g = 0; g < 2 * PER + 2; g++) begin
      if (g > 0) begin @(negedge clk); #1; end
      exp_tx = g < 2 * PER ? exp_line(b[g / PER], g % PER) : 1'b1;
      n_cmp++;
      if ({uart_tx, fifo_rd_en} !== {exp_tx, g == 0 || g == PER}) begin
        n_bad++;
        $display("FAIL toggle g=%0d tx/rd got %b want %b", g, {uart_tx, fifo_rd_en}, {exp_tx, g == 0 || g == PER});
      end
      hide = (g >= 1 && g < FL - 5) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    n_cmp++;
    if (strobes - s0 !== 2) begin
      n_bad++;
      $display("FAIL toggle_strobe_count got %0d want 2", strobes - s0);
    end
  endtask

  initial begin
    test_reset();
    byte_q = '{8'h55};
    test_stream("single_55");
    byte_q = '{8'h07};
    test_stream("single_07");
    byte_q = '{8'h03};
    test_stream("single_03");
    for (int r = 0; r < 3; r++) begin
      byte_q = '{8'($urandom)};
      test_stream("single_rand");
    end
    byte_q = '{8'hA3, 8'h0F};
    test_stream("b2b_a3_0f");
    byte_q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    test_stream("b2b_rand");
    test_reset_mid_frame(8'hFF);
    test_reset_mid_frame(8'h00);
    test_empty_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
